// File: rtl/nibble_payload_merger_pkg.sv
// Shared definitions for the nibble payload merger: nibble width, default fill,
// the delay-line slot layout and the word-to-nibble selection helper.
package nibble_payload_merger_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] DEFAULT_FILL_NIBBLE = 4'h0;

    // Widest payload word the selection helper accepts; narrower words are zero-extended.
    localparam int MAX_WORD_W = 64;

    // One nibble slot as it travels down the delay line.
    typedef struct packed {
        logic [NIBBLE_W-1:0] nibble;
        logic                user;
        logic                valid;
    } slot_t;

    // Pick nibble number idx (in transmission order) out of a word of npw nibbles.
    function automatic logic [NIBBLE_W-1:0] nib_sel(
        input logic [MAX_WORD_W-1:0] word,
        input int                    npw,
        input int                    idx,
        input logic                  msn_first
    );
        int pos;
        pos = msn_first ? (npw - 1 - idx) : idx;
        return word[pos*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/nibble_payload_merger_if.sv
// Bundle of FIFO-side and nibble-stream signals around the payload merger.
// master = the environment (FIFO + frame builder + consumer), slave = the merger.
interface nibble_payload_merger_if
    import nibble_payload_merger_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic                fifo_empty;
    logic                fifo_filled;
    logic [WIDTH-1:0]    fifo_rdata;
    logic                fifo_dequeue;
    logic [NIBBLE_W-1:0] nibble;
    logic                nibble_user_data;
    logic                nibble_valid;
    logic [NIBBLE_W-1:0] with_usr;
    logic                with_usr_valid;
    logic                start_send;
    logic                underflow;
    logic [CNT_W-1:0]    underflow_cnt;

    modport master (
        output fifo_empty, fifo_filled, fifo_rdata,
        output nibble, nibble_user_data, nibble_valid,
        input  fifo_dequeue, with_usr, with_usr_valid,
        input  start_send, underflow, underflow_cnt
    );

    modport slave (
        input  fifo_empty, fifo_filled, fifo_rdata,
        input  nibble, nibble_user_data, nibble_valid,
        output fifo_dequeue, with_usr, with_usr_valid,
        output start_send, underflow, underflow_cnt
    );
endinterface

// File: rtl/nibble_delay_line.sv
// Plain DEPTH-stage shift register; dout is the content of the last stage.
module nibble_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic         eth_clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage [DEPTH];

    // Shift the slot one stage per cycle; reset empties the line so a frame in flight is dropped.
    // NOTE: every stage is cleared on reset (it is a short register chain, not a RAM),
    // and all updates use <= so each stage reads its neighbour's pre-edge value.
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/nibble_payload_merger.sv
// Delays the nibble stream by PIPE_DEPTH cycles and replaces user-flagged slots
// with payload nibbles unpacked from FIFO words; fills on underflow and requests
// the next frame once the line is idle and the FIFO has enough data.
module nibble_payload_merger
    import nibble_payload_merger_pkg::*;
#(
    parameter int                  WIDTH       = 8,
    parameter int                  PIPE_DEPTH  = 3,
    parameter int                  MSN_FIRST   = 0,
    parameter logic [NIBBLE_W-1:0] FILL_NIBBLE = DEFAULT_FILL_NIBBLE,
    parameter int                  CNT_W       = 16
) (
    input logic                    eth_clk,
    input logic                    rst,
    nibble_payload_merger_if.slave bus
);
    localparam int NPW   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPW - 1);

    slot_t slot_in;
    slot_t slot_l;      // slot at the load point, one stage before the output

    logic [IDX_W-1:0]    nib_idx;
    logic [WIDTH-1:0]    hold;
    logic [WIDTH-1:0]    word_now;
    logic [NIBBLE_W-1:0] nib_out;
    logic                user_l;
    logic                load;

    logic                with_usr_valid_q;
    logic [NIBBLE_W-1:0] with_usr_q;
    logic                fifo_dequeue_q;
    logic                start_send_q;
    logic                underflow_q;
    logic [CNT_W-1:0]    underflow_cnt_q;

    assign slot_in = '{nibble: bus.nibble, user: bus.nibble_user_data, valid: bus.nibble_valid};

    // The line stops at the load point; the final stage is the output register below.
    nibble_delay_line #(
        .DEPTH (PIPE_DEPTH - 1),
        .W     ($bits(slot_t))
    ) u_delay (
        .eth_clk (eth_clk),
        .rst     (rst),
        .din     (slot_in),
        .dout    (slot_l)
    );

    // Decide at the load point whether a new word starts and which word feeds this slot.
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        user_l   = slot_l.user & slot_l.valid;
        load     = user_l && (nib_idx == '0);
        word_now = hold;
        if (load) begin
            word_now = bus.fifo_empty ? {NPW{FILL_NIBBLE}} : bus.fifo_rdata;
        end
        nib_out = nib_sel(MAX_WORD_W'(word_now), NPW, int'(nib_idx), MSN_FIRST != 0);
    end

    // Advance the nibble index, capture words, pop/fill accounting and the output stage.
    always_ff @(posedge eth_clk) begin
        if (rst) begin
            nib_idx          <= '0;
            hold             <= '0;
            with_usr_valid_q <= 1'b0;
            with_usr_q       <= '0;
            fifo_dequeue_q   <= 1'b0;
            start_send_q     <= 1'b0;
            underflow_q      <= 1'b0;
            underflow_cnt_q  <= '0;
        end else begin
            // A user run ending early drops the rest of the held word; the next run refetches.
            if (!user_l)                nib_idx <= '0;
            else if (nib_idx == LAST_IDX) nib_idx <= '0;
            else                        nib_idx <= nib_idx + 1'b1;

            hold           <= word_now;
            fifo_dequeue_q <= load & ~bus.fifo_empty;

            if (load && bus.fifo_empty) begin
                underflow_q <= 1'b1;
                if (underflow_cnt_q != {CNT_W{1'b1}}) underflow_cnt_q <= underflow_cnt_q + 1'b1;
            end

            with_usr_valid_q <= slot_l.valid;
            with_usr_q       <= user_l ? nib_out : slot_l.nibble;

            start_send_q <= ~with_usr_valid_q & bus.fifo_filled;
        end
    end

    assign bus.with_usr       = with_usr_q;
    assign bus.with_usr_valid = with_usr_valid_q;
    assign bus.fifo_dequeue   = fifo_dequeue_q;
    assign bus.start_send     = start_send_q;
    assign bus.underflow      = underflow_q;
    assign bus.underflow_cnt  = underflow_cnt_q;
endmodule
